// File: rtl/bus_ram_responder_pkg.sv
// Shared definitions for the load/store bus RAM responder: FSM states,
// read-zero constant and byte-to-word address helper.
package bus_ram_responder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } bus_state_t;

  localparam logic [31:0] BUS_RDZERO = 32'h0;

  function automatic logic [29:0] bus_word(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/bus_ram_responder_if.sv
// Load/store bus between the Memory stage (master) and the RAM responder (slave).
interface bus_ram_responder_if;

  logic [31:0] busaddr;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] wr_data;
  logic        rw_wait;
  logic [31:0] rd_data;

  modport master (
    output busaddr, rd_req, wr_req, wr_data,
    input  rw_wait, rd_data
  );

  modport slave (
    input  busaddr, rd_req, wr_req, wr_data,
    output rw_wait, rd_data
  );

endinterface

// File: rtl/bus_ram_responder_wait_ctr.sv
// Loadable 4-bit down-counter with zero flag; load has priority over decrement.
module bus_wait_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bus_ram_responder.sv
// Word-addressed RAM responder with programmable wait states and a one-entry
// read-hit register; rw_wait and rd_data respond in the request cycle.
module bus_ram_responder
  import bus_ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned LATENCY    = 2,
  parameter bit          HIT_EN     = 1'b1
) (
  input  logic                 clk,
  input  logic                 Nrst,
  bus_ram_responder_if.slave   bus
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  localparam logic [3:0]  LAT_LOAD  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  logic [31:0] mem [0:DEPTH-1];

  bus_state_t            state, state_nxt;
  logic [29:0]           word, off, l_addr, hit_addr;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_range, req, is_rd;
  logic                  l_rd, hit_valid;
  logic                  new_req, hit, complete, latch;
  logic                  cnt_load, cnt_dec, cnt_zero;
  logic                  rw_wait;

  assign word     = bus_word(bus.busaddr);
  assign off      = word - BASE_WORD;
  assign in_range = ((off >> DEPTH_LOG2) == '0);
  assign idx      = off[DEPTH_LOG2-1:0];
  assign req      = bus.rd_req | bus.wr_req;
  assign is_rd    = bus.rd_req;

  bus_wait_ctr u_wait_ctr (
    .clk      (clk),
    .rst_n    (Nrst),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // A WAIT-state request whose address or direction moved is handled exactly
  // like a fresh IDLE request, so the wait count restarts from LATENCY.
  always_comb begin
    state_nxt = state;
    rw_wait   = 1'b0;
    complete  = 1'b0;
    latch     = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    new_req   = (state == ST_IDLE) || (word != l_addr) || (is_rd != l_rd);
    hit       = HIT_EN && hit_valid && is_rd && (word == hit_addr);
    if (!Nrst) begin
      rw_wait   = req;
      state_nxt = ST_IDLE;
    end else if (!req) begin
      state_nxt = ST_IDLE;
    end else if (new_req) begin
      if ((LATENCY == 0) || hit) begin
        complete  = 1'b1;
        state_nxt = ST_IDLE;
      end else begin
        rw_wait   = 1'b1;
        cnt_load  = 1'b1;
        latch     = 1'b1;
        state_nxt = ST_WAIT;
      end
    end else if (!cnt_zero) begin
      rw_wait = 1'b1;
      cnt_dec = 1'b1;
    end else begin
      complete  = 1'b1;
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state     <= ST_IDLE;
      l_addr    <= '0;
      l_rd      <= 1'b0;
      hit_addr  <= '0;
      hit_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        l_addr <= word;
        l_rd   <= is_rd;
      end
      if (complete && is_rd && in_range) begin
        hit_addr  <= word;
        hit_valid <= 1'b1;
      end else if (complete && !is_rd && (word == hit_addr)) begin
        hit_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (complete && !is_rd && in_range) begin
      mem[idx] <= bus.wr_data;
    end
  end

  assign bus.rw_wait = rw_wait;
  assign bus.rd_data = (is_rd && in_range) ? mem[idx] : BUS_RDZERO;

endmodule
